add_slice_sched: RTL
====================

ADD_SLICE_SCHED -- requirements
Module: add_slice_sched

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 add request; held until gnt0.
REQ-005 a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 cin0  input  1  requester 0 carry-in.
REQ-007 req1, a1, b1, cin1  input  1/WIDTH/WIDTH/1  requester 1, same meaning.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands sampled in this cycle.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  one-cycle pulse; sum/cout/done_id valid.
REQ-011 done_id  output  1  requester that owns the completed result.
REQ-012 sum  output  WIDTH  registered result.
REQ-013 cout  output  1  registered final carry.
REQ-014 ax, ay  output  2 each  operand digits to the shared external 2-bit adder slice.
REQ-015 ac0  output  1  carry-in to the slice.
REQ-016 as  input  2  slice sum, combinational from ax/ay/ac0.
REQ-017 ac  input  1  slice carry-out.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; step counter k runs 0..WIDTH/2-1.
REQ-019 IDLE: when any request is high, SHALL assert the winner's gnt for that cycle, latch its a, b, cin and id, set k=0, and go to RUN at the next edge.
REQ-020 Arbitration: single request always wins; on simultaneous requests, round-robin against last winner; pointer after reset favours req0.
REQ-021 Requests are only sampled in IDLE; requests in RUN/DONE SHALL be ignored, and no gnt issued.
REQ-022 RUN step k: ax=A[2k+1:2k], ay=B[2k+1:2k], ac0 = latched cin when k=0, else carry register.
REQ-023 Each RUN edge: result[2k+1:2k] <= as, carry <= ac, k <= k+1; after step WIDTH/2-1, go to DONE.
REQ-024 DONE: done=1 for exactly one cycle; sum=result, cout=final carry, done_id=owner; next state IDLE.
REQ-025 Latency: gnt in cycle T -> done in cycle T+1+WIDTH/2 (WIDTH=8: T+5); earliest next gnt T+2+WIDTH/2.
REQ-026 sum, cout, done_id SHALL hold until the next done; they update only on entry to DONE.
REQ-027 In IDLE and DONE, ax, ay, ac0 SHALL be 0.
REQ-028 Arithmetic modulo 2^WIDTH; overflow reported only through cout.
REQ-029 gnt0 and gnt1 SHALL never be high together; gnt never high outside IDLE.

Reset
REQ-030 rst high at an edge SHALL force IDLE, k=0, carry=0, gnt0=gnt1=busy=done=0, sum=0, cout=0, done_id=0, ax=ay=0, ac0=0, pointer favouring req0.
REQ-031 rst mid-operation SHALL abort; no done is produced for the aborted request; rst dominates all requests.

Verification
REQ-032 req0, a0=8'h5A, b0=8'h3C, cin0=0 -> gnt0 cycle 0; ax sequence 2,2,1,1 in cycles 1-4; done cycle 5, sum=8'h96, cout=0, done_id=0.
REQ-033 a0=8'hFF, b0=8'h01, cin0=0 -> carry ripples every step; sum=8'h00, cout=1.
REQ-034 a1=8'h00, b1=8'h00, cin1=1 -> ac0=1 only in first RUN step; sum=8'h01, cout=0, done_id=1.
REQ-035 req0 and req1 both held from reset -> gnt0 cycle 0, gnt1 cycle 6, gnt0 cycle 12; never both.
REQ-036 rst asserted in RUN step 2 -> next cycle busy=0, sum=0, no done pulse; a fresh request then completes normally.
REQ-037 WIDTH=4, a=4'h9, b=4'h8, cin=1 -> done at T+3, sum=4'h2, cout=1.

Source files
------------

// File: rtl/add_slice_sched_if.sv
// Bundle of requester handshake, result and adder-slice signals for add_slice_sched.
// The slave side is the scheduler; the master side is the requesters plus the
// external 2-bit adder slice.
interface add_slice_sched_if #(
    parameter int WIDTH = 8
);
    // requester 0 / 1
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             cin0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic             gnt0;
    logic             gnt1;
    // status and result
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] sum;
    logic             cout;
    // shared external 2-bit adder slice
    logic [1:0]       ax;
    logic [1:0]       ay;
    logic             ac0;
    logic [1:0]       as;
    logic             ac;

    modport slave (
        input  req0, a0, b0, cin0, req1, a1, b1, cin1, as, ac,
        output gnt0, gnt1, busy, done, done_id, sum, cout, ax, ay, ac0
    );

    modport master (
        output req0, a0, b0, cin0, req1, a1, b1, cin1, as, ac,
        input  gnt0, gnt1, busy, done, done_id, sum, cout, ax, ay, ac0
    );
endinterface

// File: rtl/add_slice_sched.sv
// Two-requester adder that time-shares one external 2-bit adder slice.
// A granted request is processed two bits per cycle (LSB digit first), then the
// registered result is presented with a one-cycle done pulse.
module add_slice_sched #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    add_slice_sched_if.slave  bus
);
    localparam int N_DIG = WIDTH / 2;
    localparam int K_W   = $clog2(N_DIG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [K_W-1:0]   r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic             r_id;
    logic             r_carry;
    logic             r_last;        // last winner; 1 after reset so req0 wins a tie
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done_id;

    logic             w_win;         // arbitration winner id when any request is up
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_last_step;
    logic [WIDTH-1:0] w_res_next;
    logic [1:0]       w_adig [N_DIG];
    logic [1:0]       w_bdig [N_DIG];

    // Split operands into 2-bit digits and merge the slice sum into the digit
    // addressed by the step counter.
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
        assign w_adig[gi] = r_a[2*gi +: 2];
        assign w_bdig[gi] = r_b[2*gi +: 2];
        assign w_res_next[2*gi +: 2] = (r_k == K_W'(gi)) ? bus.as : r_res[2*gi +: 2];
    end

    // A lone request wins; a tie goes to the requester that did not win last.
    assign w_win       = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    assign w_last_step = (r_k == K_W'(N_DIG - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and grant decode; reset suppresses grants in its own cycle.
    always_comb begin
        w_state_next = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst && (bus.req0 || bus.req1)) begin
                    w_state_next = S_RUN;
                    w_gnt0       = ~w_win;
                    w_gnt1       = w_win;
                end
            end
            S_RUN: begin
                if (w_last_step) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, digit-serial accumulation and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
            r_id      <= 1'b0;
            r_carry   <= 1'b0;
            r_last    <= 1'b1;
            r_res     <= '0;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_done_id <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_a     <= w_gnt1 ? bus.a1   : bus.a0;
                        r_b     <= w_gnt1 ? bus.b1   : bus.b0;
                        r_cin   <= w_gnt1 ? bus.cin1 : bus.cin0;
                        r_id    <= w_gnt1;
                        r_last  <= w_gnt1;
                        r_k     <= '0;
                        r_carry <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= bus.ac;
                    if (w_last_step) begin
                        r_k       <= '0;
                        r_sum     <= w_res_next;
                        r_cout    <= bus.ac;
                        r_done_id <= r_id;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slice drive is only active while stepping; zero otherwise.
    assign bus.ax  = (r_state == S_RUN) ? w_adig[r_k] : 2'b00;
    assign bus.ay  = (r_state == S_RUN) ? w_bdig[r_k] : 2'b00;
    assign bus.ac0 = (r_state == S_RUN) ? ((r_k == '0) ? r_cin : r_carry) : 1'b0;

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
    assign bus.done_id = r_done_id;
endmodule
